// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the decode stage (decode_buffer / decode_lane).
// Optional feature macro used by this slice: DECODE_ILLEGAL_TRAP_EN.
package decode_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RALU    = 6'b000000;
  localparam logic [OP_W-1:0] OP_IALU_LO = 6'b001000;
  localparam logic [OP_W-1:0] OP_IALU_HI = 6'b001100;
  localparam logic [OP_W-1:0] OP_LOAD    = 6'b010000;
  localparam logic [OP_W-1:0] OP_LOADX   = 6'b010010;
  localparam logic [OP_W-1:0] OP_STORE   = 6'b010001;
  localparam logic [OP_W-1:0] OP_STOREX  = 6'b010011;
  localparam logic [OP_W-1:0] OP_CAS     = 6'b010100;
  localparam logic [OP_W-1:0] OP_B       = 6'b100000;
  localparam logic [OP_W-1:0] OP_BL      = 6'b100001;
  localparam logic [OP_W-1:0] OP_CBZ     = 6'b100010;
  localparam logic [OP_W-1:0] OP_CBNZ    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SYS     = 6'b111000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } queue_entry_t;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rs1_valid;
    logic             rs2_valid;
    logic             rd_valid;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  alu_func;
    logic [REG_W-1:0] shamt;
    logic             is_alu;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_cas;
    logic             illegal;
  } uop_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder producing one micro-op.
// DECODE_ILLEGAL_TRAP_EN: illegal opcodes yield a flagged uop instead of being dropped (o_emit=0).
module decode_lane
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output uop_t            o_uop,
  output logic            o_emit
);

  logic [OP_W-1:0] w_op;
  assign w_op = i_instr[31:26];

  always_comb begin
    o_uop        = '0;
    o_emit       = 1'b1;
    o_uop.opcode = w_op;
    o_uop.pc     = i_pc;
    case (w_op) inside
      OP_RALU: begin
        o_uop.rd        = i_instr[25:21];
        o_uop.rs1       = i_instr[20:16];
        o_uop.rs2       = i_instr[15:11];
        o_uop.shamt     = i_instr[10:6];
        o_uop.alu_func  = i_instr[5:0];
        o_uop.rd_valid  = 1'b1;
        o_uop.rs1_valid = 1'b1;
        o_uop.rs2_valid = 1'b1;
        o_uop.is_alu    = 1'b1;
      end
      [OP_IALU_LO:OP_IALU_HI]: begin
        o_uop.rd        = i_instr[25:21];
        o_uop.rs1       = i_instr[20:16];
        o_uop.rd_valid  = 1'b1;
        o_uop.rs1_valid = 1'b1;
        o_uop.imm       = sext16(i_instr[15:0]);
        o_uop.is_alu    = 1'b1;
      end
      OP_LOAD, OP_LOADX: begin
        o_uop.rd        = i_instr[25:21];
        o_uop.rs1       = i_instr[20:16];
        o_uop.rd_valid  = 1'b1;
        o_uop.rs1_valid = 1'b1;
        o_uop.imm       = sext16(i_instr[15:0]);
        o_uop.is_load   = 1'b1;
      end
      // Stores read the data register from the rd field position
      OP_STORE, OP_STOREX: begin
        o_uop.rs1       = i_instr[20:16];
        o_uop.rs2       = i_instr[25:21];
        o_uop.rs1_valid = 1'b1;
        o_uop.rs2_valid = 1'b1;
        o_uop.imm       = sext16(i_instr[15:0]);
        o_uop.is_store  = 1'b1;
      end
      OP_CAS: begin
        o_uop.rd        = i_instr[25:21];
        o_uop.rs1       = i_instr[20:16];
        o_uop.rs2       = i_instr[15:11];
        o_uop.rd_valid  = 1'b1;
        o_uop.rs1_valid = 1'b1;
        o_uop.rs2_valid = 1'b1;
        o_uop.is_cas    = 1'b1;
      end
      OP_B, OP_BL: begin
        o_uop.imm       = {{4{i_instr[25]}}, i_instr[25:0], 2'b00};
        o_uop.is_branch = 1'b1;
      end
      OP_CBZ, OP_CBNZ: begin
        o_uop.rs1       = i_instr[25:21];
        o_uop.rs1_valid = 1'b1;
        o_uop.imm       = {{9{i_instr[20]}}, i_instr[20:0], 2'b00};
        o_uop.is_branch = 1'b1;
      end
      OP_SYS: begin
        o_uop.imm = {{6{i_instr[25]}}, i_instr[25:0]};
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        o_uop.illegal = 1'b1;
`else
        o_emit        = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_buffer.sv
// Fetch-to-rename decode stage: circular instruction queue, DEC_W-wide decode, registered uop bundle.
// DECODE_ILLEGAL_TRAP_EN (in decode_lane) selects trap-vs-drop handling of illegal opcodes.
module decode_buffer
  import decode_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEC_W   = 2,
  parameter int unsigned DEPTH   = 8
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_pipeline,
  input  logic [FETCH_W-1:0]                instr_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]      instr,
  input  logic [FETCH_W-1:0][XLEN-1:0]      pc,
  output logic                              in_ready,
  output logic [DEC_W-1:0]                  dec_valid,
  output uop_t [DEC_W-1:0]                  dec_uop,
  input  logic                              dec_ready,
  output logic [$clog2(DEPTH):0]            q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  queue_entry_t            r_queue [DEPTH];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic [DEC_W-1:0]        r_dec_valid;
  uop_t [DEC_W-1:0]        r_dec_uop;

  logic                    w_wr_en;
  logic [CNT_W-1:0]        w_wr_cnt;
  logic [CNT_W-1:0]        w_wr_num;
  logic [PTR_W-1:0]        w_wr_idx [FETCH_W];
  logic                    w_load;
  logic [CNT_W-1:0]        w_deq_num;
  logic [CNT_W-1:0]        w_deq_eff;
  uop_t                    w_lane_uop [DEC_W];
  logic                    w_lane_emit [DEC_W];
  uop_t [DEC_W-1:0]        w_out_uop;
  logic [DEC_W-1:0]        w_out_valid;
  logic [CNT_W-1:0]        w_rank;

  assign in_ready  = (r_count <= CNT_W'(DEPTH - FETCH_W));
  assign dec_valid = r_dec_valid;
  assign dec_uop   = r_dec_uop;
  assign q_count   = r_count;

  // Compact sparse fetch lanes: each valid lane lands after all lower valid lanes
  always_comb begin
    w_wr_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_wr_idx[i] = r_tail + PTR_W'(w_wr_cnt);
      if (instr_valid[i]) w_wr_cnt = w_wr_cnt + CNT_W'(1);
    end
  end

  assign w_wr_en   = in_ready & (|instr_valid);
  assign w_wr_num  = w_wr_en ? w_wr_cnt : '0;
  assign w_load    = ~(|r_dec_valid) | dec_ready;
  assign w_deq_num = (r_count < CNT_W'(DEC_W)) ? r_count : CNT_W'(DEC_W);
  assign w_deq_eff = w_load ? w_deq_num : '0;

  for (genvar j = 0; j < DEC_W; j++) begin : g_lane
    queue_entry_t w_entry;
    assign w_entry = r_queue[r_head + PTR_W'(j)];
    decode_lane u_decode_lane (
      .i_instr (w_entry.instr),
      .i_pc    (w_entry.pc),
      .o_uop   (w_lane_uop[j]),
      .o_emit  (w_lane_emit[j])
    );
  end

  // Squeeze out dropped lanes so the emitted group stays contiguous from lane 0
  always_comb begin
    w_out_uop   = '0;
    w_out_valid = '0;
    w_rank      = '0;
    for (int j = 0; j < DEC_W; j++) begin
      if ((CNT_W'(j) < w_deq_num) && w_lane_emit[j]) begin
        for (int k = 0; k < DEC_W; k++) begin
          if (w_rank == CNT_W'(k)) w_out_uop[k] = w_lane_uop[j];
        end
        w_rank = w_rank + CNT_W'(1);
      end
    end
    for (int k = 0; k < DEC_W; k++) begin
      w_out_valid[k] = (w_rank > CNT_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (instr_valid[i]) r_queue[w_wr_idx[i]] <= '{instr: instr[i], pc: pc[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_dec_valid <= '0;
      r_dec_uop   <= '0;
    end else if (flush_pipeline) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_dec_valid <= '0;
    end else begin
      if (w_wr_en) r_tail <= r_tail + PTR_W'(w_wr_cnt);
      if (w_load) begin
        r_head      <= r_head + PTR_W'(w_deq_num);
        r_dec_valid <= w_out_valid;
        r_dec_uop   <= w_out_uop;
      end
      r_count <= r_count + w_wr_num - w_deq_eff;
    end
  end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Second-generation decode stage between fetch and rename. Fetch groups of up to FETCH_W instructions, including sparse ones, go into a DEPTH-entry circular instruction queue. Each cycle the block decodes up to DEC_W of the oldest queued instructions into a registered micro-op bundle with a valid/ready handshake. Fetch and rename are decoupled, pipeline flushes are handled, and illegal opcodes can be reported instead of silently dropped.

## Interface
- FETCH_W, 2, fetch lanes written per cycle (1..4)
- DEC_W, 2, decoded lanes emitted per cycle (1..4)
- DEPTH, 8, queue entries; power of two, at least 2*FETCH_W
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush_pipeline  in  1  synchronous flush; highest priority
- instr_valid  in  FETCH_W  per-lane valid (may be sparse, e.g. 2'b10)
- instr  in  FETCH_W x 32  instruction words
- pc  in  FETCH_W x 32  per-lane PC
- in_ready  out  1  queue free entries >= FETCH_W (combinational from count)
- dec_valid  out  DEC_W  registered; contiguous from lane 0
- dec_uop  out  DEC_W x decode_pkg::uop_t  registered decoded micro-ops
- dec_ready  in  1  rename accepts the whole output group this cycle
- q_count  out  $clog2(DEPTH)+1  current queue occupancy (debug/perf)

## Operation
- Enqueue: when in_ready and any instr_valid, valid lanes are compacted in lane order (lowest lane = oldest) and written at tail; tail += popcount(instr_valid). in_ready low: fetch holds its inputs.
- Decode (per head entry, via decode_lane): opcode = instr[31:26].
  - 000000 R-ALU: rd=[25:21], rs1=[20:16], rs2=[15:11], shamt=[10:6], func=[5:0]; rd/rs1/rs2 valid; is_alu.
  - 001000..001100 I-ALU: rd, rs1, imm=sext([15:0]); is_alu.
  - 010000/010010 load: rd, rs1, imm=sext16; is_load.
  - 010001/010011 store: rs1=[20:16], rs2=[25:21], imm=sext16; is_store.
  - 010100 CAS: rd, rs1, rs2; is_cas.
  - 100000/100001 B: imm=sext({[25:0],2'b00}); is_branch.
  - 100010/100011 CB: rs1=[25:21], imm=sext({[20:0],2'b00}); is_branch.
  - 111000 system: imm=sext([25:0]); no class flag.
  - Any other opcode: illegal (see Configuration).
  - Unused fields are 0; pc copied from the queue entry.
- Dequeue: output register loads when dec_valid==0 or dec_ready. It takes n = min(DEC_W, count) head entries; head += n; dec_valid = (1<<n)-1.
- A group presented but not accepted is held stable until dec_ready.
- Enqueue and dequeue in the same cycle: count += written - n. Wrap-around uses mod-DEPTH pointer arithmetic.
- Flush: the next edge sets head=tail=0, count=0, dec_valid=0. Same-cycle enqueue and dequeue are discarded.

## Timing
- Reset (async): head=tail=count=0, dec_valid=0, dec_uop=0, q_count=0. in_ready=1 once reset deasserts.
- Latency: instruction written at edge N reaches the queue head in cycle N+1 and the output register at edge N+1 (dec_valid in cycle N+1 after that edge). Minimum fetch-to-rename is one cycle after enqueue.
- Throughput: min(FETCH_W, DEC_W) per cycle sustained with dec_ready held high.
- Full: count > DEPTH-FETCH_W drops in_ready. Queue never overflows.
- Empty: no output load, so dec_valid falls after the accepted group when count==0.
- Reset mid-operation: all state cleared immediately; no partial group survives.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: an illegal opcode produces a valid uop with uop.illegal=1, all class flags 0, and no register valids, so the ROB raises an exception in order.
- Undefined: illegal entries are removed from the group; surviving lanes are re-compacted and the head still advances past them. The uop.illegal field remains and is tied to 0.

## Structure
- decode_pkg: uop_t packed struct (opcode, rs1, rs2, rd, rs1/rs2/rd_valid, imm, pc, alu_func, shamt, is_alu/load/store/branch/cas, illegal); opcode localparams; queue_entry_t {instr, pc}.
- Sub-module decode_lane: combinational single-instruction decoder, instantiated DEC_W times.
- decode_buffer holds the queue, pointers, compaction and output register.

## Test plan
- Reset, then FETCH_W=2 lanes valid=2'b11 with ADDI (0x2022_0005) and LDUR: next cycle dec_valid=2'b11, uop0.imm=5, uop0.is_alu, uop1.is_load.
- Sparse valid=2'b10 with CB 0x8860_0003: dec_valid=2'b01, lane0 rs1=3, imm=0xC, is_branch.
- dec_ready=0 for 6 cycles with continuous fetch: in_ready drops once count>6; output held stable; no entry lost or duplicated (scoreboard by PC).
- Queue at count=5, flush asserted while enqueuing: next cycle count=0, dec_valid=0; the enqueued instructions are never emitted.
- Opcode 0x3F with the macro defined: uop.illegal=1, dec_valid set. Without the macro the lane is skipped and the next instruction occupies lane 0.
- Assert reset with 4 entries queued and dec_valid=2'b11: all outputs 0 asynchronously; resumes cleanly after deassert.
